// File: rtl/bitmap_scaler_sdl_gen_if.sv
// bitmap_scaler_sdl_gen_if
// Bus bundle for the scaled bitmap SDL generator.
//   write side : i_wr_en/i_wr_addr/i_wr_data  bitmap RAM write port
//                i_pal_we/i_pal_idx/i_pal_rgb palette write port
//                i_swap_req                   buffer swap request (double-buffer builds)
//   video side : o_sdl_hpos/o_sdl_vpos/o_sdl_visible/o_sdl_r/g/b pixel bundle
//                o_hsync/o_vsync              sync strobes, aligned with the bundle
//                o_swap_done                  one-cycle swap strobe
// master = loader/CPU model + display consumer, slave = the generator.
interface bitmap_scaler_sdl_gen_if #(
    parameter int AW  = 15,
    parameter int BPP = 2
);
    logic           i_wr_en;
    logic [AW-1:0]  i_wr_addr;
    logic [BPP-1:0] i_wr_data;
    logic           i_pal_we;
    logic [BPP-1:0] i_pal_idx;
    logic [23:0]    i_pal_rgb;
    logic           i_swap_req;
    logic           o_swap_done;
    logic [9:0]     o_sdl_hpos;
    logic [9:0]     o_sdl_vpos;
    logic           o_sdl_visible;
    logic [7:0]     o_sdl_r;
    logic [7:0]     o_sdl_g;
    logic [7:0]     o_sdl_b;
    logic           o_hsync;
    logic           o_vsync;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_pal_we, i_pal_idx, i_pal_rgb, i_swap_req,
        input  o_swap_done, o_sdl_hpos, o_sdl_vpos, o_sdl_visible,
               o_sdl_r, o_sdl_g, o_sdl_b, o_hsync, o_vsync
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_pal_we, i_pal_idx, i_pal_rgb, i_swap_req,
        output o_swap_done, o_sdl_hpos, o_sdl_vpos, o_sdl_visible,
               o_sdl_r, o_sdl_g, o_sdl_b, o_hsync, o_vsync
    );
endinterface

// File: rtl/bitmap_scaler_sdl_gen.sv
// bitmap_scaler_sdl_gen
// Video timing generator with an integer-scaled, palettised bitmap and a
// 2-stage pixel pipeline (RAM read, palette lookup). Every field of the
// output bundle is delayed by the same 2 cycles so it is self-consistent.
// Ports:
//   i_clk    pixel clock
//   i_rst_n  asynchronous active-low reset
//   bus      bitmap_scaler_sdl_gen_if.slave (write ports, swap, SDL bundle, syncs)
// Optional feature macro: BITMAP_DOUBLE_BUFFER_EN
//   defined   : two RAM banks, writes go to the back bank, swap at vblank start
//   undefined : one bank, i_swap_req ignored, o_swap_done tied low
module bitmap_scaler_sdl_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int BMP_W     = 160,
    parameter int BMP_H     = 120,
    parameter int SCALE     = 4,
    parameter int BPP       = 2
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    bitmap_scaler_sdl_gen_if.slave bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DEPTH   = BMP_W * BMP_H;
    localparam int AW      = $clog2(DEPTH);
    // Row base runs past the bitmap during blanking; the extra bits keep
    // it from wrapping back into valid addresses before the frame ends.
    localparam int RW      = AW + 11;
`ifdef BITMAP_DOUBLE_BUFFER_EN
    localparam int NBANK   = 2;
`else
    localparam int NBANK   = 1;
`endif
    localparam int IW      = $clog2(NBANK * DEPTH);
    localparam int NPAL    = 1 << BPP;

    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    S_LAST   = 10'(SCALE - 1);
    localparam logic [9:0]    H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0]    V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0]    HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0]    HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0]    VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0]    VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0]    BMP_W10  = 10'(BMP_W);
    localparam logic [9:0]    BMP_H10  = 10'(BMP_H);
    localparam logic [RW-1:0] ROW_STEP = RW'(BMP_W);
    localparam logic [RW-1:0] BANK_OFF = RW'(DEPTH);
    localparam logic [RW-1:0] DEPTH_RW = RW'(DEPTH);

    function automatic logic [23:0] pal_default(input int idx);
        case (idx)
            1:       return 24'hFF0000;
            2:       return 24'h00FF00;
            3:       return 24'hFFFFFF;
            default: return 24'h000000;
        endcase
    endfunction

    logic [9:0]    hpos, vpos;
    logic [9:0]    sx, bx, sy, by;
    logic [RW-1:0] rowbase;

    // Scale sub-counters replace the divide: bx = hpos/SCALE, by = vpos/SCALE,
    // rowbase = by*BMP_W, all maintained incrementally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hpos    <= '0;
            vpos    <= '0;
            sx      <= '0;
            bx      <= '0;
            sy      <= '0;
            by      <= '0;
            rowbase <= '0;
        end else if (hpos == H_LAST) begin
            hpos <= '0;
            sx   <= '0;
            bx   <= '0;
            if (vpos == V_LAST) begin
                vpos    <= '0;
                sy      <= '0;
                by      <= '0;
                rowbase <= '0;
            end else begin
                vpos <= vpos + 10'd1;
                if (sy == S_LAST) begin
                    sy      <= '0;
                    by      <= by + 10'd1;
                    rowbase <= rowbase + ROW_STEP;
                end else begin
                    sy <= sy + 10'd1;
                end
            end
        end else begin
            hpos <= hpos + 10'd1;
            if (sx == S_LAST) begin
                sx <= '0;
                bx <= bx + 10'd1;
            end else begin
                sx <= sx + 10'd1;
            end
        end
    end

    logic visible, active, hsync_c, vsync_c;
    assign visible = (hpos < H_VIS) && (vpos < V_VIS);
    // bx < BMP_W is hpos < BMP_W*SCALE without the multiply (same for by).
    assign active  = (bx < BMP_W10) && (by < BMP_H10);
    assign hsync_c = (hpos >= HS_START) && (hpos < HS_END);
    assign vsync_c = (vpos >= VS_START) && (vpos < VS_END);

    logic [RW-1:0] rd_off, wr_off;

`ifdef BITMAP_DOUBLE_BUFFER_EN
    logic front, swap_pend, swap_now;

    // A request landing in the swap cycle itself is folded into this swap.
    assign swap_now = (hpos == '0) && (vpos == V_VIS) && (swap_pend || bus.i_swap_req);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            front     <= 1'b0;
            swap_pend <= 1'b0;
        end else if (swap_now) begin
            front     <= ~front;
            swap_pend <= 1'b0;
        end else if (bus.i_swap_req) begin
            swap_pend <= 1'b1;
        end
    end

    assign bus.o_swap_done = swap_now;
    assign rd_off = front ? BANK_OFF : '0;
    assign wr_off = front ? '0 : BANK_OFF;
`else
    logic unused_swap_req;
    assign unused_swap_req = bus.i_swap_req;
    assign bus.o_swap_done = 1'b0;
    assign rd_off = '0;
    assign wr_off = '0;
`endif

    logic [BPP-1:0] ram [NBANK*DEPTH];
    logic [BPP-1:0] rd_idx;
    logic [IW-1:0]  rd_ix, wr_ix;
    logic           wr_ok;

    assign rd_ix = IW'(rowbase + RW'(bx) + rd_off);
    assign wr_ix = IW'(RW'(bus.i_wr_addr) + wr_off);
    assign wr_ok = bus.i_wr_en && (RW'(bus.i_wr_addr) < DEPTH_RW);

    // Bitmap contents survive reset; a same-address read sees the old word.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            ram[wr_ix] <= bus.i_wr_data;
        end
        if (visible && active) begin
            rd_idx <= ram[rd_ix];
        end
    end

    logic [23:0] pal [NPAL];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NPAL; i++) begin
                pal[i] <= pal_default(i);
            end
        end else if (bus.i_pal_we) begin
            pal[bus.i_pal_idx] <= bus.i_pal_rgb;
        end
    end

    logic [9:0] s1_hpos, s1_vpos;
    logic       s1_vis, s1_show, s1_hs, s1_vs;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_hpos <= '0;
            s1_vpos <= '0;
            s1_vis  <= 1'b0;
            s1_show <= 1'b0;
            s1_hs   <= 1'b0;
            s1_vs   <= 1'b0;
        end else begin
            s1_hpos <= hpos;
            s1_vpos <= vpos;
            s1_vis  <= visible;
            s1_show <= visible && active;
            s1_hs   <= hsync_c;
            s1_vs   <= vsync_c;
        end
    end

    logic [23:0] pix_rgb;
    assign pix_rgb = s1_show ? pal[rd_idx] : 24'h000000;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bus.o_sdl_hpos    <= '0;
            bus.o_sdl_vpos    <= '0;
            bus.o_sdl_visible <= 1'b0;
            bus.o_sdl_r       <= '0;
            bus.o_sdl_g       <= '0;
            bus.o_sdl_b       <= '0;
            bus.o_hsync       <= 1'b0;
            bus.o_vsync       <= 1'b0;
        end else begin
            bus.o_sdl_hpos    <= s1_hpos;
            bus.o_sdl_vpos    <= s1_vpos;
            bus.o_sdl_visible <= s1_vis;
            bus.o_sdl_r       <= pix_rgb[23:16];
            bus.o_sdl_g       <= pix_rgb[15:8];
            bus.o_sdl_b       <= pix_rgb[7:0];
            bus.o_hsync       <= s1_hs;
            bus.o_vsync       <= s1_vs;
        end
    end
endmodule
